// File: rtl/spi_flash_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_master_if
// Brief    : CPU-side register strobes and readback of the SPI flash master.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_flash_master_if;
    logic        wr_data;
    logic        wr_ctrl;
    logic        rd_data;
    logic [15:0] din;
    logic [7:0]  rx_data;
    logic [2:0]  status;

    // The CPU decode drives the strobes; the SPI block answers with readback.
    modport master (
        output wr_data,
        output wr_ctrl,
        output rd_data,
        output din,
        input  rx_data,
        input  status
    );

    modport slave (
        input  wr_data,
        input  wr_ctrl,
        input  rd_data,
        input  din,
        output rx_data,
        output status
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_master
// Brief    : IO-mapped mode-0 SPI master, MSB first, 8-bit frames, boot flash.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_master #(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 2
) (
    input  logic              clk,
    input  logic              resetq,
    spi_flash_master_if.slave bus,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam logic [DIV_W-1:0] c_div_reset = DIV_W'(DIV_RESET);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_hc;
    logic [DIV_W-1:0]   r_div_l;
    logic [DIV_W-1:0]   r_div;
    logic [7:0]         r_shift;
    logic [2:0]         r_bitcnt;
    logic               r_sck;
    logic               r_mosi;
    logic               r_cs_n;
    logic               r_busy;
    logic               r_rx_valid;
    logic               r_err;
    logic [7:0]         r_rx_data;

    state_t             w_state;
    logic [DIV_W-1:0]   w_hc;
    logic [DIV_W-1:0]   w_div_l;
    logic [DIV_W-1:0]   w_div;
    logic [7:0]         w_shift;
    logic [2:0]         w_bitcnt;
    logic               w_sck;
    logic               w_mosi;
    logic               w_cs_n;
    logic               w_busy;
    logic               w_rx_valid;
    logic               w_err;
    logic [7:0]         w_rx_data;

    logic               w_hc_done;
    logic [7:0]         w_shift_in;

    assign w_hc_done  = (r_hc == r_div_l);
    assign w_shift_in = {r_shift[6:0], miso};

    always_comb begin
        w_state    = r_state;
        w_hc       = r_hc;
        w_div_l    = r_div_l;
        w_div      = r_div;
        w_shift    = r_shift;
        w_bitcnt   = r_bitcnt;
        w_sck      = r_sck;
        w_mosi     = r_mosi;
        w_cs_n     = r_cs_n;
        w_busy     = r_busy;
        w_rx_valid = r_rx_valid;
        w_err      = r_err;
        w_rx_data  = r_rx_data;

        // Control writes are applied first so frame events below can override them.
        if (bus.wr_ctrl) begin
            w_div = bus.din[8 +: DIV_W];
            if (!r_busy) begin
                w_cs_n = ~bus.din[0];
            end
            if (bus.din[1]) begin
                w_err = 1'b0;
            end
        end

        if (bus.rd_data) begin
            w_rx_valid = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (bus.wr_data) begin
                    w_shift  = bus.din[7:0];
                    w_mosi   = bus.din[7];
                    w_bitcnt = 3'd0;
                    w_hc     = '0;
                    w_div_l  = r_div;
                    w_busy   = 1'b1;
                    w_state  = ST_LOW;
                end
            end

            ST_LOW: begin
                if (w_hc_done) begin
                    w_sck   = 1'b1;
                    w_hc    = '0;
                    w_state = ST_HIGH;
                end else begin
                    w_hc = r_hc + 1'b1;
                end
            end

            ST_HIGH: begin
                if (w_hc_done) begin
                    // miso is taken on the last high cycle to absorb the IO-cell register.
                    w_sck   = 1'b0;
                    w_shift = w_shift_in;
                    w_hc    = '0;
                    if (r_bitcnt == 3'd7) begin
                        w_rx_data  = w_shift_in;
                        w_rx_valid = 1'b1;
                        w_busy     = 1'b0;
                        w_mosi     = 1'b0;
                        w_state    = ST_IDLE;
                        if (r_rx_valid) begin
                            w_err = 1'b1;
                        end
                    end else begin
                        w_bitcnt = r_bitcnt + 3'd1;
                        w_mosi   = r_shift[6];
                        w_state  = ST_LOW;
                    end
                end else begin
                    w_hc = r_hc + 1'b1;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // A write while a frame is in flight is dropped and flagged; this beats a clear.
        if (bus.wr_data && r_busy) begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state    <= ST_IDLE;
            r_hc       <= '0;
            r_div_l    <= '0;
            r_div      <= c_div_reset;
            r_shift    <= 8'h00;
            r_bitcnt   <= 3'd0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_rx_data  <= 8'h00;
        end else begin
            r_state    <= w_state;
            r_hc       <= w_hc;
            r_div_l    <= w_div_l;
            r_div      <= w_div;
            r_shift    <= w_shift;
            r_bitcnt   <= w_bitcnt;
            r_sck      <= w_sck;
            r_mosi     <= w_mosi;
            r_cs_n     <= w_cs_n;
            r_busy     <= w_busy;
            r_rx_valid <= w_rx_valid;
            r_err      <= w_err;
            r_rx_data  <= w_rx_data;
        end
    end

    assign bus.rx_data = r_rx_data;
    assign bus.status  = {r_err, r_rx_valid, r_busy};
    assign sck         = r_sck;
    assign mosi        = r_mosi;
    assign cs_n        = r_cs_n;

endmodule
`default_nettype wire

// File: doc/spi_flash_master.md
Name: spi_flash_master

Overview:
- IO-mapped SPI master (mode 0, MSB first, 8-bit frames) for the boot flash on PIOS_00..03.
- Replaces bit-banging SCK/MOSI/CS through the misc.out register.
- Sits between the top-level registered IO decode (io_wr_/io_rd_/dout_ strobes) and the flash pin drivers.
- CPU writes a byte to start a frame, polls busy, then reads the received byte.

Parameters:
- DIV_W, 8, width of clock-divider field.
- DIV_RESET, 2, divider value after reset.

Ports:
- clk  in  1  system clock
- resetq  in  1  reset; asynchronous, active-low
- wr_data  in  1  1-cycle strobe: load tx byte din[7:0] and start a frame
- wr_ctrl  in  1  1-cycle strobe: din[0]=cs assert, din[1]=clear err, din[8+DIV_W-1:8]=div
- rd_data  in  1  1-cycle strobe: CPU consumed rx_data; clears rx_valid
- din  in  16  write data from CPU
- rx_data  out  8  last received byte
- status  out  3  {err, rx_valid, busy}
- sck  out  1  SPI clock to flash
- mosi  out  1  SPI data to flash
- miso  in  1  SPI data from flash (already registered once in the IO cell)
- cs_n  out  1  flash chip select, active-low

Behaviour:
- Reset (async on resetq low):
  - cs_n=1, sck=0, mosi=0, busy=0, rx_valid=0, err=0, rx_data=0, div=DIV_RESET, FSM=IDLE.
  - Reset mid-frame aborts immediately with the same values; no partial rx_data update.
- Outputs: all are registered; status is a direct register read.
- FSM states: IDLE, LOW, HIGH.
  - Half-period counter hc counts 0..div_l, where div_l is div latched at frame start. Each SCK phase lasts div_l+1 clk cycles.
- Start of frame:
  - Trigger: wr_data while IDLE.
  - Next edge: shift<=din[7:0], mosi<=din[7], bitcnt<=0, hc<=0, div_l<=div, busy<=1, state<=LOW.
- LOW state:
  - sck=0. When hc==div_l: sck<=1, hc<=0, state<=HIGH.
- HIGH state:
  - sck=1. When hc==div_l: sck<=0, shift<={shift[6:0],miso}, hc<=0.
  - miso is sampled on the last HIGH cycle, which tolerates the input-register delay.
  - If bitcnt==7: rx_data<={shift[6:0],miso}, rx_valid<=1, busy<=0, mosi<=0, state<=IDLE.
  - Else: bitcnt++, mosi<=shift[6], state<=LOW.
- Frame length: exactly 16*(div+1) cycles from the edge after wr_data to the busy 1->0 edge; 8 SCK rising edges.
- wr_data while busy: ignored (shift/mosi untouched); err<=1 (sticky).
- wr_ctrl:
  - Always updates div; the new div takes effect at the next frame only.
  - cs_n<=~din[0] only when not busy; ignored while busy.
  - din[1]=1 clears err. Simultaneous set (wr_data while busy) and clear: set wins.
- rd_data clears rx_valid.
  - Same cycle as frame completion: completion wins, rx_valid=1, rx_data = new byte.
- rx_valid already 1 at frame completion: overwrite rx_data, set err=1.
- wr_data and wr_ctrl in the same IDLE cycle: both take effect. The frame uses the old div; cs_n updates.
- cs_n is never changed by the FSM; software brackets frames.

Test Plan:
1. After reset: wr_ctrl din=0x0001, wr_data 0xA5, miso looped to mosi.
   - busy=1 for 16 cycles; 8 sck pulses each 1 high/1 low.
   - mosi sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; status=3'b010; cs_n=0 throughout.
2. wr_ctrl din=0x0301 (div=3), wr_data 0x3C, miso tied 1.
   - sck high/low phases of 4 cycles; busy falls 64 cycles after start; rx_data=0xFF.
3. wr_data 0x12 then wr_data 0x34 during the frame.
   - Second write ignored; rx_data=0x12 loopback; err=1.
   - wr_ctrl din=0x0003 -> err=0, cs_n=0.
4. rd_data pulsed on the exact completion cycle of a frame sending 0x5A.
   - rx_valid stays 1; rx_data=0x5A.
   - Next rd_data -> rx_valid=0.
5. resetq low at bit 4 of a frame.
   - Immediately cs_n=1, sck=0, mosi=0, busy=0, rx_data=0, div=2.
   - After release, a new frame runs with 3-cycle phases.
6. wr_ctrl din=0x0000 while busy.
   - cs_n stays 0 until the frame ends; the new div applies only to the following frame.
